rv_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the RV32IMC 3-stage core's instruction fetch
//  (pc/instr) and data load/store ports. Arbitrates one RAM access per cycle and issues grants.

---
 rtl/rv_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - fetch/load/store arbiter for a single-port SRAM with misaligned fetch split.
// Optional RV_MEM_ARB_MISALIGN_CHK_EN adds the c_misalign output and suppresses misaligned writes.
module rv_mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              c_arst,
  input  logic [31:0]       pc,
  input  logic              c_ifetch,
  output logic              c_if_gnt,
  output logic [31:0]       instr,
  output logic              c_instr_valid,
  input  logic [31:0]       dmem_load_addr,
  input  logic              c_dmem_load,
  output logic              c_ld_gnt,
  output logic [31:0]       dmem_load_data,
  output logic              c_load_valid,
  input  logic [31:0]       dmem_store_addr,
  input  logic [31:0]       dmem_store_data,
  input  logic [1:0]        dmem_store_width,
  input  logic              c_dmem_store,
  output logic              c_st_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              c_ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
  ,
  output logic              c_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, FETCH_HI} state_e;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rd_fetch_q, rd_fetch_d;
  logic              rd_mis_q, rd_mis_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [15:0]       lo_q, lo_d;

  logic              fetch_resp, fetch_cont, fetch_block;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              unused_bits;

  assign unused_bits = ^{pc[31:ADDR_W+2], pc[0], dmem_load_addr[31:ADDR_W+2],
                         dmem_load_addr[1:0], dmem_store_addr[31:ADDR_W+2]};

`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
  logic st_mis, ld_mis, misalign_q;
  // Loads carry no width of their own; they share the LSU width signal with stores.
  assign st_mis = (dmem_store_width == 2'd1 && dmem_store_addr[0]) ||
                  (dmem_store_width == 2'd2 && dmem_store_addr[1:0] != 2'b00);
  assign ld_mis = (dmem_store_width == 2'd1 && dmem_load_addr[0]) ||
                  (dmem_store_width == 2'd2 && dmem_load_addr[1:0] != 2'b00);
  assign c_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (c_arst) misalign_q <= 1'b0;
    else        misalign_q <= (c_st_gnt && st_mis) || (c_ld_gnt && ld_mis);
  end
`endif

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = dmem_store_data;
    case (dmem_store_width)
      2'd0: begin
        st_be    = 4'b0001 << dmem_store_addr[1:0];
        st_wdata = {4{dmem_store_data[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << {dmem_store_addr[1], 1'b0};
        st_wdata = {2{dmem_store_data[15:0]}};
      end
      2'd2:    st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
    if (st_mis) st_be = 4'b0000;
`endif
  end

  assign fetch_resp  = (state_q == RD_WAIT) && rd_fetch_q;
  // Upper halfword of a misaligned fetch is the start of a 32-bit instruction.
  assign fetch_cont  = fetch_resp && rd_mis_q && (ram_rdata[17:16] == 2'b11);
  assign fetch_block = fetch_resp || (state_q == FETCH_HI);

  always_comb begin
    state_d        = IDLE;
    starve_d       = starve_q;
    rd_fetch_d     = rd_fetch_q;
    rd_mis_d       = rd_mis_q;
    word_d         = word_q;
    lo_d           = lo_q;
    c_if_gnt       = 1'b0;
    c_ld_gnt       = 1'b0;
    c_st_gnt       = 1'b0;
    c_instr_valid  = 1'b0;
    instr          = 32'h0;
    c_load_valid   = 1'b0;
    dmem_load_data = 32'h0;
    c_ram_en       = 1'b0;
    ram_we         = 1'b0;
    ram_be         = 4'b0000;
    ram_wdata      = 32'h0;
    ram_addr       = '0;

    if (!c_arst) begin
      if (state_q == RD_WAIT) begin
        if (!rd_fetch_q) begin
          c_load_valid   = 1'b1;
          dmem_load_data = ram_rdata;
        end else if (!rd_mis_q) begin
          c_instr_valid = 1'b1;
          instr         = ram_rdata;
        end else if (!fetch_cont) begin
          c_instr_valid = 1'b1;
          instr         = {16'h0, ram_rdata[31:16]};
        end
      end else if (state_q == FETCH_HI) begin
        c_instr_valid = 1'b1;
        instr         = {ram_rdata[15:0], lo_q};
      end

      if (fetch_cont) begin
        c_ram_en = 1'b1;
        ram_addr = word_q + ADDR_W'(1);
        lo_d     = ram_rdata[31:16];
        state_d  = FETCH_HI;
      end else if (c_ifetch && !fetch_block && starve_q == SW'(STARVE_MAX)) begin
        c_if_gnt = 1'b1;
      end else if (c_dmem_store) begin
        c_st_gnt = 1'b1;
      end else if (c_dmem_load) begin
        c_ld_gnt = 1'b1;
      end else if (c_ifetch && !fetch_block) begin
        c_if_gnt = 1'b1;
      end

      if (c_if_gnt) begin
        c_ram_en   = 1'b1;
        ram_addr   = pc[ADDR_W+1:2];
        word_d     = pc[ADDR_W+1:2];
        rd_fetch_d = 1'b1;
        rd_mis_d   = pc[1];
        state_d    = RD_WAIT;
      end else if (c_ld_gnt) begin
        c_ram_en   = 1'b1;
        ram_addr   = dmem_load_addr[ADDR_W+1:2];
        rd_fetch_d = 1'b0;
        rd_mis_d   = 1'b0;
        state_d    = RD_WAIT;
      end else if (c_st_gnt) begin
        c_ram_en  = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = dmem_store_addr[ADDR_W+1:2];
        ram_be    = st_be;
        ram_wdata = st_wdata;
      end

      if (c_if_gnt)                                       starve_d = '0;
      else if (c_ifetch && starve_q != SW'(STARVE_MAX))   starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (c_arst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rd_fetch_q <= 1'b0;
      rd_mis_q   <= 1'b0;
      word_q     <= '0;
      lo_q       <= 16'h0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_fetch_q <= rd_fetch_d;
      rd_mis_q   <= rd_mis_d;
      word_q     <= word_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - self-checking bench for rv_mem_arbiter with SRAM and byte-level reference memory.
module tb_rv_mem_arbiter;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        c_arst;
  logic [31:0] pc;
  logic        c_ifetch, c_if_gnt, c_instr_valid;
  logic [31:0] instr;
  logic [31:0] dmem_load_addr, dmem_load_data;
  logic        c_dmem_load, c_ld_gnt, c_load_valid;
  logic [31:0] dmem_store_addr, dmem_store_data;
  logic [1:0]  dmem_store_width;
  logic        c_dmem_store, c_st_gnt;
  logic [13:0] ram_addr;
  logic        c_ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
  logic        c_misalign;
`endif

  logic [31:0] sram  [0:16383];
  logic [7:0]  ref_b [0:65535];
  logic        bd_we;
  logic [13:0] bd_addr;
  logic [31:0] bd_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .c_arst(c_arst), .pc(pc), .c_ifetch(c_ifetch), .c_if_gnt(c_if_gnt),
    .instr(instr), .c_instr_valid(c_instr_valid), .dmem_load_addr(dmem_load_addr),
    .c_dmem_load(c_dmem_load), .c_ld_gnt(c_ld_gnt), .dmem_load_data(dmem_load_data),
    .c_load_valid(c_load_valid), .dmem_store_addr(dmem_store_addr),
    .dmem_store_data(dmem_store_data), .dmem_store_width(dmem_store_width),
    .c_dmem_store(c_dmem_store), .c_st_gnt(c_st_gnt), .ram_addr(ram_addr),
    .c_ram_en(c_ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
    , .c_misalign(c_misalign)
`endif
  );

  // SRAM plus a byte-addressed reference memory updated from the store request itself.
  always @(posedge clk) begin
    if (bd_we) begin
      sram[bd_addr] <= bd_data;
      for (int k = 0; k < 4; k++) ref_b[{bd_addr, 2'(k)}] <= bd_data[8*k +: 8];
    end
    if (c_ram_en) begin
      if (ram_we)
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      ram_rdata <= sram[ram_addr];
    end
    if (c_st_gnt
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
        && !(dmem_store_width == 2'd1 && dmem_store_addr[0])
        && !(dmem_store_width == 2'd2 && dmem_store_addr[1:0] != 2'b00)
`endif
       ) begin
      case (dmem_store_width)
        2'd0: ref_b[dmem_store_addr[15:0]] <= dmem_store_data[7:0];
        2'd1: begin
          ref_b[{dmem_store_addr[15:1], 1'b0}] <= dmem_store_data[7:0];
          ref_b[{dmem_store_addr[15:1], 1'b1}] <= dmem_store_data[15:8];
        end
        2'd2: for (int k = 0; k < 4; k++)
                ref_b[{dmem_store_addr[15:2], 2'(k)}] <= dmem_store_data[8*k +: 8];
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] ref_word(input logic [13:0] w);
    return {ref_b[{w, 2'd3}], ref_b[{w, 2'd2}], ref_b[{w, 2'd1}], ref_b[{w, 2'd0}]};
  endfunction

  function automatic logic [15:0] ref_half(input logic [15:0] a);
    return {ref_b[{a[15:1], 1'b1}], ref_b[{a[15:1], 1'b0}]};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [15:0] lo;
    lo = ref_half(a[15:0]);
    if (!a[1]) return ref_word(a[15:2]);
    if (lo[1:0] != 2'b11) return {16'h0, lo};
    return {ref_half(a[15:0] + 16'd2), lo};
  endfunction

  function automatic int exp_lat(input logic [31:0] a);
    logic [15:0] lo;
    lo = ref_half(a[15:0]);
    return (a[1] && lo[1:0] == 2'b11) ? 2 : 1;
  endfunction

  task automatic idle_all();
    c_ifetch = 1'b0; c_dmem_load = 1'b0; c_dmem_store = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic mem_put(input logic [13:0] w, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = w; bd_data = v;
    next_cycle();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    c_ifetch = 1'b1; pc = 32'h0;
    c_dmem_load = 1'b1; dmem_load_addr = 32'h8;
    c_dmem_store = 1'b1; dmem_store_addr = 32'h40; dmem_store_width = 2'd2; dmem_store_data = 32'h11223344;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, c_ld_gnt, c_st_gnt} !== 3'b000) $display("FAIL rst_grants: got %b exp 000", {c_if_gnt, c_ld_gnt, c_st_gnt}); else n_pass++;
    n_checks++; if ({c_instr_valid, c_load_valid} !== 2'b00) $display("FAIL rst_valids: got %b exp 00", {c_instr_valid, c_load_valid}); else n_pass++;
    n_checks++; if ({c_ram_en, ram_we, ram_be} !== 6'h0) $display("FAIL rst_ram_ctl: got %b exp 0", {c_ram_en, ram_we, ram_be}); else n_pass++;
    n_checks++; if ({instr, dmem_load_data, ram_addr} !== 78'h0) $display("FAIL rst_data: got %h exp 0", {instr, dmem_load_data, ram_addr}); else n_pass++;
    next_cycle(); c_arst = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, c_ld_gnt, c_st_gnt} !== 3'b001) $display("FAIL rst_first_store: got %b exp 001", {c_if_gnt, c_ld_gnt, c_st_gnt}); else n_pass++;
    next_cycle(); idle_all();
    c_dmem_load = 1'b1; dmem_load_addr = 32'h8;
    @(negedge clk);
    n_checks++; if (c_ld_gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b exp 1", c_ld_gnt); else n_pass++;
    next_cycle(); c_dmem_load = 1'b0; c_arst = 1'b1;
    @(negedge clk);
    n_checks++; if (c_load_valid !== 1'b0) $display("FAIL rst_mid_drop: got %b exp 0", c_load_valid); else n_pass++;
    next_cycle(); c_arst = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_load_valid, c_instr_valid} !== 2'b00) $display("FAIL rst_mid_after: got %b exp 00", {c_load_valid, c_instr_valid}); else n_pass++;
    next_cycle();
  endtask

  task automatic test_store_lanes();
    logic [31:0] a, d, ed;
    logic [1:0]  w;
    logic [13:0] ea;
    logic [3:0]  eb;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin a = 32'h6;  w = 2'd0; d = 32'h123456A5; ea = 14'd1; eb = 4'b0100; ed = 32'hA5A5A5A5; end
        1:       begin a = 32'h12; w = 2'd1; d = 32'h0000BEEF; ea = 14'd4; eb = 4'b1100; ed = 32'hBEEFBEEF; end
        2:       begin a = 32'h20; w = 2'd2; d = 32'hCAFEF00D; ea = 14'd8; eb = 4'b1111; ed = 32'hCAFEF00D; end
        default: begin a = 32'h8;  w = 2'd3; d = 32'hFFFFFFFF; ea = 14'd2; eb = 4'b0000; ed = 32'h0; end
      endcase
      c_dmem_store = 1'b1; dmem_store_addr = a; dmem_store_width = w; dmem_store_data = d;
      @(negedge clk);
      n_checks++; if ({c_st_gnt, ram_addr, ram_be} !== {1'b1, ea, eb}) $display("FAIL st_lane%0d: got gnt/addr/be %b/%h/%b exp 1/%h/%b", i, c_st_gnt, ram_addr, ram_be, ea, eb); else n_pass++;
      if (i != 3) begin
        n_checks++; if ({ram_we, ram_wdata} !== {1'b1, ed}) $display("FAIL st_wdata%0d: got we/wdata %b/%h exp 1/%h", i, ram_we, ram_wdata, ed); else n_pass++;
      end
      next_cycle(); c_dmem_store = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      c_dmem_load = 1'b1; dmem_load_addr = (i == 0) ? 32'h4 : 32'h10;
      @(negedge clk);
      next_cycle(); c_dmem_load = 1'b0;
      @(negedge clk);
      n_checks++; if (!c_load_valid || dmem_load_data !== ref_word(dmem_load_addr[15:2])) $display("FAIL st_readback%0d: got %b/%h exp 1/%h", i, c_load_valid, dmem_load_data, ref_word(dmem_load_addr[15:2])); else n_pass++;
      n_checks++; if ((i == 0 && dmem_load_data[23:16] !== 8'hA5) || (i == 1 && dmem_load_data[31:16] !== 16'hBEEF)) $display("FAIL st_lane_byte%0d: got %h", i, dmem_load_data); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_priority();
    c_dmem_store = 1'b1; dmem_store_addr = 32'h14; dmem_store_width = 2'd2; dmem_store_data = 32'h5555AAAA;
    c_dmem_load = 1'b1; dmem_load_addr = 32'h8;
    c_ifetch = 1'b1; pc = 32'h0;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, c_ld_gnt, c_st_gnt} !== 3'b001) $display("FAIL prio_n: got %b exp 001", {c_if_gnt, c_ld_gnt, c_st_gnt}); else n_pass++;
    next_cycle(); c_dmem_store = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, c_ld_gnt, c_st_gnt} !== 3'b010) $display("FAIL prio_n1: got %b exp 010", {c_if_gnt, c_ld_gnt, c_st_gnt}); else n_pass++;
    next_cycle(); c_dmem_load = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, c_load_valid, dmem_load_data} !== {2'b11, ref_word(14'd2)}) $display("FAIL prio_n2: got %b%b/%h exp 11/%h", c_if_gnt, c_load_valid, dmem_load_data, ref_word(14'd2)); else n_pass++;
    next_cycle(); c_ifetch = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_instr_valid, c_load_valid, instr} !== {2'b10, ref_word(14'd0)}) $display("FAIL prio_n3: got %b%b/%h exp 10/%h", c_instr_valid, c_load_valid, instr, ref_word(14'd0)); else n_pass++;
    next_cycle();
  endtask

  task automatic test_compressed();
    mem_put(14'd0, 32'h1234_0001);
    c_ifetch = 1'b1; pc = 32'h2;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, ram_addr} !== {1'b1, 14'd0}) $display("FAIL cmp_gnt: got %b/%h exp 1/0", c_if_gnt, ram_addr); else n_pass++;
    next_cycle(); c_ifetch = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_instr_valid, instr, c_ram_en} !== {1'b1, 32'h0000_1234, 1'b0}) $display("FAIL cmp_instr: got %b/%h/%b exp 1/00001234/0", c_instr_valid, instr, c_ram_en); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if (c_instr_valid !== 1'b0) $display("FAIL cmp_once: got %b exp 0", c_instr_valid); else n_pass++;
    next_cycle();
  endtask

  task automatic test_fetch_hi();
    mem_put(14'd0, 32'h0013_ABCD);
    mem_put(14'd1, 32'h9876_0050);
    c_ifetch = 1'b1; pc = 32'h2;
    @(negedge clk);
    n_checks++; if (c_if_gnt !== 1'b1) $display("FAIL hi_gnt: got %b exp 1", c_if_gnt); else n_pass++;
    next_cycle(); c_ifetch = 1'b0; c_dmem_load = 1'b1; dmem_load_addr = 32'h10;
    @(negedge clk);
    n_checks++; if ({c_ram_en, ram_we, ram_addr, c_ld_gnt, c_instr_valid} !== {2'b10, 14'd1, 2'b00}) $display("FAIL hi_read: got en/we/addr/ldg/iv %b/%b/%h/%b/%b exp 1/0/1/0/0", c_ram_en, ram_we, ram_addr, c_ld_gnt, c_instr_valid); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if ({c_instr_valid, instr} !== {1'b1, 32'h0050_0013}) $display("FAIL hi_instr: got %b/%h exp 1/00500013", c_instr_valid, instr); else n_pass++;
    n_checks++; if (c_ld_gnt !== 1'b1) $display("FAIL hi_ld_after: got %b exp 1", c_ld_gnt); else n_pass++;
    next_cycle(); c_dmem_load = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_load_valid, dmem_load_data} !== {1'b1, ref_word(14'd4)}) $display("FAIL hi_ld_data: got %b/%h exp 1/%h", c_load_valid, dmem_load_data, ref_word(14'd4)); else n_pass++;
    next_cycle();
  endtask

  task automatic test_wrap();
    mem_put(14'h3FFF, 32'h0013_0000);
    mem_put(14'd0, 32'h0000_7777);
    c_ifetch = 1'b1; pc = 32'hABCD_FFFE;
    @(negedge clk);
    n_checks++; if ({c_if_gnt, ram_addr} !== {1'b1, 14'h3FFF}) $display("FAIL wrap_gnt: got %b/%h exp 1/3fff", c_if_gnt, ram_addr); else n_pass++;
    next_cycle(); c_ifetch = 1'b0;
    @(negedge clk);
    n_checks++; if ({c_ram_en, ram_addr} !== {1'b1, 14'h0}) $display("FAIL wrap_hi_addr: got %b/%h exp 1/0", c_ram_en, ram_addr); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if ({c_instr_valid, instr} !== {1'b1, 32'h7777_0013}) $display("FAIL wrap_instr: got %b/%h exp 1/77770013", c_instr_valid, instr); else n_pass++;
    next_cycle();
  endtask

  task automatic test_starvation();
    int  lost;
    bit  got;
    lost = 0; got = 1'b0;
    c_dmem_store = 1'b1; dmem_store_addr = 32'h50; dmem_store_width = 2'd2; dmem_store_data = $urandom();
    c_ifetch = 1'b1; pc = 32'h4;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (c_if_gnt) got = 1'b1;
      else begin
        if (c_st_gnt) lost++;
        next_cycle();
      end
    end
    n_checks++; if (!got || lost != STARVE_MAX) $display("FAIL starve_lost: got grant=%0d after %0d lost exp 1 after %0d", got, lost, STARVE_MAX); else n_pass++;
    n_checks++; if (c_st_gnt !== 1'b0) $display("FAIL starve_excl: got st_gnt %b exp 0", c_st_gnt); else n_pass++;
    next_cycle(); idle_all();
    @(negedge clk);
    n_checks++; if ({c_instr_valid, instr} !== {1'b1, ref_word(14'd1)}) $display("FAIL starve_instr: got %b/%h exp 1/%h", c_instr_valid, instr, ref_word(14'd1)); else n_pass++;
    next_cycle();
  endtask

`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
  task automatic test_misalign();
    c_dmem_store = 1'b1; dmem_store_addr = 32'h3; dmem_store_width = 2'd2; dmem_store_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if ({c_st_gnt, ram_be} !== 5'b10000) $display("FAIL mis_be: got %b/%b exp 1/0000", c_st_gnt, ram_be); else n_pass++;
    next_cycle(); c_dmem_store = 1'b0;
    @(negedge clk);
    n_checks++; if (c_misalign !== 1'b1) $display("FAIL mis_flag: got %b exp 1", c_misalign); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if (c_misalign !== 1'b0) $display("FAIL mis_clear: got %b exp 0", c_misalign); else n_pass++;
    next_cycle();
  endtask
`endif

  task automatic test_random();
    bit          f_req, l_req, s_req, f_pend, l_pend;
    int          f_due, l_due, f_lost, cyc, ngnt;
    logic [31:0] f_exp, l_exp;
    f_req = 0; l_req = 0; s_req = 0; f_pend = 0; l_pend = 0;
    f_due = 0; l_due = 0; f_lost = 0; cyc = 0; f_exp = 0; l_exp = 0;
    for (int w = 0; w < 16; w++) mem_put(14'(w), $urandom());
    mem_put(14'h3FFF, $urandom());
    for (int i = 0; i < 800; i++) begin
      if (!f_req && $urandom_range(0, 99) < 50) begin
        f_req = 1;
        pc = ($urandom_range(0, 7) == 0) ? {16'($urandom()), 16'hFFFE}
                                         : {16'($urandom()), 16'($urandom_range(0, 31) * 2)};
      end
      if (!l_req && $urandom_range(0, 99) < 30) begin
        l_req = 1; dmem_load_addr = {16'($urandom()), 16'($urandom_range(0, 63))};
      end
      if (!s_req && $urandom_range(0, 99) < 30) begin
        s_req = 1; dmem_store_addr = {16'($urandom()), 16'($urandom_range(0, 63))};
        dmem_store_width = 2'($urandom_range(0, 3)); dmem_store_data = $urandom();
      end
      c_ifetch = f_req; c_dmem_load = l_req; c_dmem_store = s_req;
      @(negedge clk); cyc++;
      n_checks++; if (c_load_valid !== (l_pend && l_due == cyc)) $display("FAIL rnd_ld_valid cyc %0d: got %b", cyc, c_load_valid); else n_pass++;
      if (c_load_valid && l_pend && l_due == cyc) begin
        n_checks++; if (dmem_load_data !== l_exp) $display("FAIL rnd_ld_data cyc %0d: got %h exp %h", cyc, dmem_load_data, l_exp); else n_pass++;
        l_pend = 0;
      end
      n_checks++; if (c_instr_valid !== (f_pend && f_due == cyc)) $display("FAIL rnd_if_valid cyc %0d: got %b", cyc, c_instr_valid); else n_pass++;
      if (c_instr_valid && f_pend && f_due == cyc) begin
        n_checks++; if (instr !== f_exp) $display("FAIL rnd_instr cyc %0d: got %h exp %h", cyc, instr, f_exp); else n_pass++;
        f_pend = 0;
      end
      ngnt = int'(c_if_gnt) + int'(c_ld_gnt) + int'(c_st_gnt);
      n_checks++; if (ngnt > 1 || (c_if_gnt && !f_req) || (c_ld_gnt && !l_req) || (c_st_gnt && !s_req)) $display("FAIL rnd_grant cyc %0d: got %b with req %b", cyc, {c_if_gnt, c_ld_gnt, c_st_gnt}, {f_req, l_req, s_req}); else n_pass++;
      if (f_req) begin
        if (c_if_gnt) begin
          n_checks++; if (f_lost > STARVE_MAX) $display("FAIL rnd_starve cyc %0d: got %0d lost exp <= %0d", cyc, f_lost, STARVE_MAX); else n_pass++;
          f_lost = 0;
        end else f_lost++;
      end
      if (c_ld_gnt) begin l_pend = 1; l_due = cyc + 1; l_exp = ref_word(dmem_load_addr[15:2]); l_req = 0; end
      if (c_if_gnt) begin f_pend = 1; f_due = cyc + exp_lat(pc); f_exp = exp_instr(pc); f_req = 0; end
      if (c_st_gnt) s_req = 0;
      next_cycle();
    end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    c_arst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    pc = '0; dmem_load_addr = '0; dmem_store_addr = '0; dmem_store_data = '0; dmem_store_width = '0;
    idle_all();
    next_cycle();
    for (int w = 0; w < 16; w++) mem_put(14'(w), $urandom());
    test_reset();
    test_store_lanes();
    test_priority();
    test_compressed();
    test_fetch_hi();
    test_wrap();
    test_starvation();
`ifdef RV_MEM_ARB_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
